// File: rtl/arith_mc_alu.sv
// Multi-cycle signed add/subtract unit with accumulator; CHUNK bits per clock, carry registered.
// Saturation on signed overflow, sticky overflow flag, start/busy/done handshake.
module arith_mc_alu #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sat,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             clr_acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             OV,
  output logic             ov_sticky,
  output logic [WIDTH-1:0] acc
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t r_state, w_next;

  logic [WIDTH-1:0]       r_x, r_y;
  logic [WIDTH-CHUNK-1:0] r_sum;
  logic [CW-1:0]          r_cnt;
  logic                   r_carry, r_sat, r_acc_op, r_xmsb, r_ymsb;

  logic                   w_accept, w_last, w_cout, w_ov;
  logic [CHUNK-1:0]       w_s;
  logic [WIDTH-1:0]       w_sum, w_satv, w_res, w_left, w_right, w_rinv;

  // A new op may be accepted on the edge leaving DONE, giving one op per N+1 cycles.
  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_state == S_CALC) && (r_cnt == CW'(N - 1));

  // Operands shift right each cycle so the working chunk always sits at bit 0.
  assign {w_cout, w_s} = {1'b0, r_x[CHUNK-1:0]} + {1'b0, r_y[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  assign w_sum  = {w_s, r_sum};
  assign w_ov   = (r_xmsb == r_ymsb) && (w_sum[WIDTH-1] != r_xmsb);
  assign w_satv = r_xmsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign w_res  = (r_sat && w_ov) ? w_satv : w_sum;

  // op 1x computes acc +/- A, so acc becomes the left operand.
  assign w_left  = op[1] ? acc : A;
  assign w_right = op[1] ? A : B;
  assign w_rinv  = op[0] ? ~w_right : w_right;

  assign busy = (r_state == S_CALC);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CALC;
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_CALC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_sat    <= 1'b0;
      r_acc_op <= 1'b0;
      r_xmsb   <= 1'b0;
      r_ymsb   <= 1'b0;
    end else if (w_accept) begin
      r_x      <= w_left;
      r_y      <= w_rinv;
      r_xmsb   <= w_left[WIDTH-1];
      r_ymsb   <= w_rinv[WIDTH-1];
      r_carry  <= op[0];
      r_sat    <= sat;
      r_acc_op <= op[1];
      r_cnt    <= '0;
    end else if (r_state == S_CALC) begin
      r_x     <= r_x >> CHUNK;
      r_y     <= r_y >> CHUNK;
      r_sum   <= w_sum[WIDTH-1:CHUNK];
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      OV        <= 1'b0;
      ov_sticky <= 1'b0;
      acc       <= '0;
    end else begin
      if (w_last) begin
        result <= w_res;
        OV     <= w_ov;
      end
      // Clear dominates a simultaneous completion update.
      if (clr_acc) begin
        acc       <= '0;
        ov_sticky <= 1'b0;
      end else if (w_last) begin
        ov_sticky <= ov_sticky | w_ov;
        if (r_acc_op) acc <= w_res;
      end
    end
  end
endmodule
